// File: rtl/fixed_point_add_sub_pipe.sv
// Segmented carry-pipelined N-bit adder/subtractor: one SEG-bit slice resolved per stage,
// valid/ready stream interface, signed/unsigned overflow and optional saturation.
module fixed_point_add_sub_pipe #(
  parameter int N        = 32,
  parameter int SEG      = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  input  logic         op_sub,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         carry_out,
  output logic         overflow,
  output logic         saturated
);

  localparam int S = N / SEG;
  localparam logic [N-1:0] SMIN = N'(1) << (N - 1);

  generate
    if ((N % SEG) != 0 || S < 1) begin : g_bad_params
      $error("fixed_point_add_sub_pipe: N must be a non-zero multiple of SEG");
    end
  endgenerate

  // Per-stage registers; entry k holds the item after segment k has been resolved
  logic         r_valid [S];
  logic [N-1:0] r_a     [S];
  logic [N-1:0] r_bp    [S];
  logic [N-1:0] r_sum   [S];
  logic         r_cy    [S];
  logic         r_sgn   [S];
  logic         r_sub   [S];
  logic         r_ovf;
  logic         r_sat;

  // Stage inputs and combinational results
  logic         w_vin    [S];
  logic [N-1:0] w_ain    [S];
  logic [N-1:0] w_bpin   [S];
  logic [N-1:0] w_sumin  [S];
  logic         w_cyin   [S];
  logic         w_sgnin  [S];
  logic         w_subin  [S];
  logic [SEG:0] w_seg    [S];
  logic [N-1:0] w_sum_res[S];
  logic [N-1:0] w_sum_nx [S];

  logic         w_adv;
  logic [N-1:0] w_c_fin;
  logic         w_ovf;
  logic         w_sat;
  logic         w_sovf;
  logic         w_cout;
  logic         w_a_msb;
  logic         w_bp_msb;

  assign w_adv    = !r_valid[S-1] | out_ready;
  assign in_ready = w_adv;

  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_stage
      localparam logic [N-1:0] MASK = N'({SEG{1'b1}}) << (gi * SEG);

      if (gi == 0) begin : g_first
        assign w_vin[gi]   = in_valid;
        assign w_ain[gi]   = a;
        assign w_bpin[gi]  = op_sub ? ~b : b;
        assign w_sumin[gi] = '0;
        assign w_cyin[gi]  = carry_in;
        assign w_sgnin[gi] = is_signed;
        assign w_subin[gi] = op_sub;
      end else begin : g_next
        assign w_vin[gi]   = r_valid[gi-1];
        assign w_ain[gi]   = r_a[gi-1];
        assign w_bpin[gi]  = r_bp[gi-1];
        assign w_sumin[gi] = r_sum[gi-1];
        assign w_cyin[gi]  = r_cy[gi-1];
        assign w_sgnin[gi] = r_sgn[gi-1];
        assign w_subin[gi] = r_sub[gi-1];
      end

      assign w_seg[gi] = {1'b0, w_ain[gi][gi*SEG +: SEG]}
                       + {1'b0, w_bpin[gi][gi*SEG +: SEG]}
                       + {{SEG{1'b0}}, w_cyin[gi]};

      // Drop this stage's slice into the partially resolved sum
      assign w_sum_res[gi] = (w_sumin[gi] & ~MASK)
                           | (N'(w_seg[gi][SEG-1:0]) << (gi * SEG));

      if (gi == S - 1) begin : g_last
        assign w_sum_nx[gi] = w_c_fin;
      end else begin : g_mid
        assign w_sum_nx[gi] = w_sum_res[gi];
      end
    end
  endgenerate

  // Flags and clamping are resolved in the last stage, ahead of its register
  assign w_cout   = w_seg[S-1][SEG];
  assign w_a_msb  = w_ain[S-1][N-1];
  assign w_bp_msb = w_bpin[S-1][N-1];
  assign w_sovf   = (w_a_msb == w_bp_msb) & (w_sum_res[S-1][N-1] != w_a_msb);
  assign w_ovf    = w_sgnin[S-1] ? w_sovf : (w_subin[S-1] ? !w_cout : w_cout);
  assign w_sat    = SATURATE & w_ovf;

  always_comb begin
    w_c_fin = w_sum_res[S-1];
    if (w_sat) begin
      if (w_sgnin[S-1]) begin
        w_c_fin = w_a_msb ? SMIN : ~SMIN;
      end else if (w_subin[S-1]) begin
        w_c_fin = '0;
      end else begin
        w_c_fin = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_bp[k]    <= '0;
        r_sum[k]   <= '0;
        r_cy[k]    <= 1'b0;
        r_sgn[k]   <= 1'b0;
        r_sub[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
      r_sat <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < S; k++) begin
        r_valid[k] <= w_vin[k];
        r_a[k]     <= w_ain[k];
        r_bp[k]    <= w_bpin[k];
        r_sum[k]   <= w_sum_nx[k];
        r_cy[k]    <= w_seg[k][SEG];
        r_sgn[k]   <= w_sgnin[k];
        r_sub[k]   <= w_subin[k];
      end
      r_ovf <= w_ovf;
      r_sat <= w_sat;
    end
  end

  assign out_valid = r_valid[S-1];
  assign c         = r_sum[S-1];
  assign carry_out = r_cy[S-1];
  assign overflow  = r_ovf;
  assign saturated = r_sat;

endmodule

// File: tb/tb_fixed_point_add_sub_pipe.sv
// Drives a wrapping and a saturating instance with shared stimulus and checks both
// against a plain-arithmetic reference model through an in-order scoreboard.
module tb_fixed_point_add_sub_pipe;

  localparam int N   = 32;
  localparam int SEG = 8;
  localparam int S   = N / SEG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         carry_in = 1'b0;
  logic         op_sub = 1'b0;
  logic         is_signed = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;

  logic         in_ready_w, out_valid_w, cout_w, ovf_w, sat_w;
  logic         in_ready_s, out_valid_s, cout_s, ovf_s, sat_s;
  logic [N-1:0] c_w, c_s;

  always #5 clk = ~clk;

  fixed_point_add_sub_pipe #(.N(N), .SEG(SEG), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .carry_in(carry_in), .op_sub(op_sub), .is_signed(is_signed),
    .out_valid(out_valid_w), .out_ready(out_ready), .c(c_w),
    .carry_out(cout_w), .overflow(ovf_w), .saturated(sat_w)
  );

  fixed_point_add_sub_pipe #(.N(N), .SEG(SEG), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .carry_in(carry_in), .op_sub(op_sub), .is_signed(is_signed),
    .out_valid(out_valid_s), .out_ready(out_ready), .c(c_s),
    .carry_out(cout_s), .overflow(ovf_s), .saturated(sat_s)
  );

  typedef struct {
    logic [N-1:0] cw;
    logic [N-1:0] cs;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           chk_lat;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    bit           cin;
    bit           sub;
    bit           sgn;
    logic [N-1:0] cw;
    logic [N-1:0] cs;
    bit           cout;
    bit           ovf;
  } dir_t;

  dir_t dirs [10] = '{
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1},
    '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1'b1},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h1234_5678, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 32'h1234_5778, 32'h1234_5778, 1'b0, 1'b0},
    '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0},
    '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1},
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1}
  };

  exp_t         q [$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           held = 1'b0;
  logic [N-1:0] held_c;
  logic         held_cout;
  bit           last_acc;
  bit           last_pop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: wide-integer add, overflow from the true mathematical result range
  function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                 input bit cin, input bit sub, input bit sgn);
    exp_t         e;
    logic [N-1:0] bp;
    logic [N:0]   u;
    longint       s;
    bit           sovf;
    bp     = sub ? ~ib : ib;
    u      = {1'b0, ia} + {1'b0, bp} + {{N{1'b0}}, cin};
    s      = longint'($signed(ia)) + longint'($signed(bp)) + longint'(cin);
    sovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.cw   = u[N-1:0];
    e.cout = u[N];
    e.ovf  = sgn ? sovf : (sub ? !u[N] : u[N]);
    if (!e.ovf)   e.cs = e.cw;
    else if (sgn) e.cs = ia[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (sub) e.cs = 32'h0000_0000;
    else          e.cs = 32'hFFFF_FFFF;
    e.acc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // One clock cycle: drive at negedge, evaluate handshakes, then wait for the next negedge
  task automatic step(input bit v, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input bit cin, input bit sub, input bit sgn, input bit ordy,
                      input exp_t e_in, input bit lat);
    exp_t e;
    in_valid  = v;
    a         = ia;
    b         = ib;
    carry_in  = cin;
    op_sub    = sub;
    is_signed = sgn;
    out_ready = ordy;
    #1;
    if (held) begin
      check("stall_valid", out_valid_w, 1);
      check("stall_c", c_w, held_c);
      check("stall_cout", cout_w, held_cout);
    end
    held      = out_valid_w && !out_ready;
    held_c    = c_w;
    held_cout = cout_w;
    last_pop  = out_valid_w && out_ready;
    if (last_pop) begin
      check("out_has_item", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("c_wrap", c_w, e.cw);
        check("c_sat", c_s, e.cs);
        check("cout_w", cout_w, e.cout);
        check("cout_s", cout_s, e.cout);
        check("ovf_w", ovf_w, e.ovf);
        check("ovf_s", ovf_s, e.ovf);
        check("sat_w", sat_w, 0);
        check("sat_s", sat_s, e.ovf);
        check("valid_s", out_valid_s, 1);
        if (e.chk_lat) check("latency", cyc - e.acc, S);
      end
    end
    last_acc = in_valid && in_ready_w;
    if (last_acc) begin
      e         = e_in;
      e.acc     = cyc;
      e.chk_lat = lat;
      q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    exp_t z;
    z = '{default: '0};
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, z, 1'b0);
  endtask

  task automatic send_rand(input bit v, input bit ordy, input bit lat);
    logic [N-1:0] ia, ib;
    bit           cin, sub, sgn;
    ia  = $urandom;
    ib  = $urandom;
    case ($urandom_range(0, 7))
      0:       ia = 32'hFFFF_FFFF;
      1:       ia = 32'h7FFF_FFFF;
      2:       ia = 32'h8000_0000;
      3:       ib = 32'h0000_0000;
      default: ;
    endcase
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    sgn = 1'($urandom_range(0, 1));
    step(v, ia, ib, cin, sub, sgn, ordy, model(ia, ib, cin, sub, sgn), lat);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
    check(tag, q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent;
    int   n;
    exp_t e;

    // Reset with in_valid asserted: nothing may enter
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid_w, 0);
    check("rst_valid_s", out_valid_s, 0);
    check("rst_c", c_w, 0);
    check("rst_cout", cout_w, 0);
    check("rst_ovf", ovf_w, 0);
    check("rst_sat", sat_s, 0);
    rst_n = 1'b1;
    for (int i = 0; i < S + 2; i++) idle(1'b1);
    check("post_rst_valid", out_valid_w, 0);

    // Directed corner cases, one at a time, latency checked
    for (int i = 0; i < 10; i++) begin
      e         = '{default: '0};
      e.cw      = dirs[i].cw;
      e.cs      = dirs[i].cs;
      e.cout    = dirs[i].cout;
      e.ovf     = dirs[i].ovf;
      step(1'b1, dirs[i].a, dirs[i].b, dirs[i].cin, dirs[i].sub, dirs[i].sgn, 1'b1, e, 1'b1);
      check("dir_accept", last_acc, 1);
      drain("dir_drain");
    end

    // Random stream with random valid and ready
    sent = 0;
    for (int g = 0; g < 5000 && sent < 100; g++) begin
      send_rand($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
      if (last_acc) sent++;
    end
    check("rand_sent", sent, 100);
    drain("rand_drain");

    // Fill while stalled, hold, then drain one per cycle
    n = 0;
    for (int i = 0; i < 3 * S; i++) begin
      send_rand(1'b1, 1'b0, 1'b0);
      if (!last_acc) break;
      n++;
    end
    check("fill_count", n, S);
    for (int i = 0; i < 3; i++) begin
      send_rand(1'b1, 1'b0, 1'b0);
      check("full_no_accept", last_acc, 0);
    end
    for (int i = 0; i < S; i++) begin
      idle(1'b1);
      check("drain_pop", last_pop, 1);
    end
    idle(1'b1);
    check("drain_empty", last_pop, 0);
    check("drain_queue", q.size(), 0);

    // Asynchronous reset with items in flight
    for (int i = 0; i < 3; i++) send_rand(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !out_valid_w; i++) idle(1'b0);
    check("pre_rst_valid", out_valid_w, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid_w, 0);
    check("async_rst_valid_s", out_valid_s, 0);
    check("async_rst_c", c_w, 0);
    check("async_rst_ovf", ovf_w, 0);
    q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_rand(1'b1, 1'b1, 1'b1);
    check("post_rst_accept", last_acc, 1);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
